// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge
//   Host debug/loading bus initiator driven by a UART byte stream. A frame is
//   CMD, four little-endian address bytes and, for writes, four little-endian
//   data bytes. Each frame produces one single-beat bus access. The bridge
//   answers with a STATUS byte, followed by four read-data bytes when a read
//   completes OK.
//
// Ports
//   clk_i, rst_i      system clock, asynchronous active-high reset
//   rx_valid_i        one-cycle strobe: rx_data_i holds a received byte
//   rx_data_i[7:0]    received byte
//   tx_full_i         TX FIFO full
//   tx_req_o          one-cycle push of tx_data_o into the TX FIFO
//   tx_data_o[7:0]    byte to transmit, valid while tx_req_o is high
//   addr_o            bus address (upper frame address bytes truncated)
//   w_rb_o            1 = write, 0 = read
//   acc_o[1:0]        access size: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes
//   wdata_o[31:0]     write data, lane 0 = first data byte
//   req_o             one-cycle bus request
//   rdata_i[31:0]     read data, valid with resp_i
//   resp_i            access complete
//   fault_i           combinational reject, valid in the req_o cycle
//   busy_o            high whenever the bridge is not idle
module uart_bus_bridge #(
    parameter int ADDR_WIDTH    = 32,
    parameter int BUS_TIMEOUT   = 255,
    parameter int FRAME_TIMEOUT = 65535
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_valid_i,
    input  logic [7:0]            rx_data_i,
    input  logic                  tx_full_i,
    output logic                  tx_req_o,
    output logic [7:0]            tx_data_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic                  w_rb_o,
    output logic [1:0]            acc_o,
    output logic [31:0]           wdata_o,
    output logic                  req_o,
    input  logic [31:0]           rdata_i,
    input  logic                  resp_i,
    input  logic                  fault_i,
    output logic                  busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        REQ,
        WAIT,
        RSP_ST,
        RSP_DAT
    } state_t;

    localparam logic [1:0]  ST_OK      = 2'd0;
    localparam logic [1:0]  ST_FAULT   = 2'd1;
    localparam logic [1:0]  ST_TIMEOUT = 2'd2;
    localparam logic [1:0]  ST_BADCMD  = 2'd3;
    localparam logic [7:0]  BusLimit   = 8'(BUS_TIMEOUT);
    // Idle counter is compared before incrementing, so the frame is dropped
    // on the FRAME_TIMEOUT-th consecutive idle cycle.
    localparam logic [15:0] FrameLimit = 16'(FRAME_TIMEOUT - 1);

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [7:0]  tmo_q;
    logic [15:0] idle_q;
    logic [1:0]  status_q;
    logic        ovr_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        w_rb_q;
    logic [1:0]  acc_q;
    logic        req_q;
    logic        busy_q;
    logic        rx_drop;

    // A byte arriving while an access or a response is in flight cannot be
    // parsed; it is dropped and flagged in the next STATUS byte.
    assign rx_drop = rx_valid_i && ((state_q == REQ) || (state_q == WAIT) ||
                                    (state_q == RSP_ST) || (state_q == RSP_DAT));

    assign addr_o  = addr_q[ADDR_WIDTH-1:0];
    assign wdata_o = wdata_q;
    assign w_rb_o  = w_rb_q;
    assign acc_o   = acc_q;
    assign req_o   = req_q;
    assign busy_o  = busy_q;

    // The TX push is gated combinationally by tx_full_i so that a push can
    // never coincide with a full FIFO, even when tx_full_i rises unannounced.
    always_comb begin
        tx_req_o  = 1'b0;
        tx_data_o = 8'h00;
        case (state_q)
            RSP_ST: begin
                tx_req_o  = ~tx_full_i;
                tx_data_o = {ovr_q, 5'b00000, status_q};
            end
            RSP_DAT: begin
                tx_req_o  = ~tx_full_i;
                tx_data_o = rdata_q[{cnt_q, 3'b000} +: 8];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= 2'd0;
            tmo_q    <= 8'd0;
            idle_q   <= 16'd0;
            status_q <= ST_OK;
            ovr_q    <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            w_rb_q   <= 1'b0;
            acc_q    <= 2'd0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid_i) begin
                        w_rb_q <= rx_data_i[7];
                        acc_q  <= rx_data_i[1:0];
                        cnt_q  <= 2'd0;
                        idle_q <= 16'd0;
                        busy_q <= 1'b1;
                        if ((rx_data_i[6:2] != 5'd0) || (rx_data_i[1:0] == 2'd3)) begin
                            status_q <= ST_BADCMD;
                            state_q  <= RSP_ST;
                        end else begin
                            state_q <= ADDR;
                        end
                    end
                end
                ADDR: begin
                    if (rx_valid_i) begin
                        addr_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
                        idle_q <= 16'd0;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            if (w_rb_q) begin
                                state_q <= DATA;
                            end else begin
                                state_q <= REQ;
                                req_q   <= 1'b1;
                            end
                        end
                    end else if (idle_q == FrameLimit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
                end
                DATA: begin
                    if (rx_valid_i) begin
                        wdata_q[{cnt_q, 3'b000} +: 8] <= rx_data_i;
                        idle_q <= 16'd0;
                        cnt_q  <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= REQ;
                            req_q   <= 1'b1;
                        end
                    end else if (idle_q == FrameLimit) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_q <= idle_q + 16'd1;
                    end
                end
                REQ: begin
                    req_q <= 1'b0;
                    if (fault_i) begin
                        status_q <= ST_FAULT;
                        state_q  <= RSP_ST;
                    end else begin
                        tmo_q   <= 8'd0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (resp_i) begin
                        rdata_q  <= rdata_i;
                        status_q <= ST_OK;
                        state_q  <= RSP_ST;
                    end else if (tmo_q == BusLimit) begin
                        status_q <= ST_TIMEOUT;
                        state_q  <= RSP_ST;
                    end else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
                end
                RSP_ST: begin
                    if (!tx_full_i) begin
                        ovr_q <= 1'b0;
                        cnt_q <= 2'd0;
                        if (!w_rb_q && (status_q == ST_OK)) begin
                            state_q <= RSP_DAT;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                RSP_DAT: begin
                    if (!tx_full_i) begin
                        cnt_q <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    req_q   <= 1'b0;
                end
            endcase
            // Placed last so that a byte dropped during the STATUS push is
            // still reported in the following STATUS.
            if (rx_drop) begin
                ovr_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_bridge.sv
// tb_uart_bus_bridge
//   Drives UART command frames into uart_bus_bridge, emulates the bus slave
//   and the TX FIFO, and compares the bus accesses and transmitted bytes with
//   the responses predicted from the frame contents.
module tb_uart_bus_bridge;

    localparam int FT = 200;
    localparam int BT = 255;

    logic        clock = 1'b0;
    logic        reset;
    logic        rxValid;
    logic [7:0]  rxData;
    logic        txFull;
    logic        txReq;
    logic [7:0]  txData;
    logic [31:0] addr;
    logic        wRb;
    logic [1:0]  acc;
    logic [31:0] wdata;
    logic        req;
    logic [31:0] rdata = 32'd0;
    logic        resp  = 1'b0;
    logic        fault = 1'b0;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    // Bus slave behaviour knobs, set by the stimulus sequence.
    bit          faultMode  = 1'b0;
    bit          respEnable = 1'b1;
    int          respDelay  = 1;
    logic [31:0] rdataVal   = 32'd0;
    int          respCnt    = 0;

    // Observed activity, collected once per cycle.
    int          cyc = 0;
    int          reqCyc = 0;
    int          lastTxCyc = 0;
    int          fullViolations = 0;
    logic [7:0]  txLog[$];
    logic [31:0] reqAddr[$];
    logic [31:0] reqWdata[$];
    logic        reqW[$];
    logic [1:0]  reqAcc[$];

    uart_bus_bridge #(
        .ADDR_WIDTH   (32),
        .BUS_TIMEOUT  (BT),
        .FRAME_TIMEOUT(FT)
    ) dut (
        .clk_i     (clock),
        .rst_i     (reset),
        .rx_valid_i(rxValid),
        .rx_data_i (rxData),
        .tx_full_i (txFull),
        .tx_req_o  (txReq),
        .tx_data_o (txData),
        .addr_o    (addr),
        .w_rb_o    (wRb),
        .acc_o     (acc),
        .wdata_o   (wdata),
        .req_o     (req),
        .rdata_i   (rdata),
        .resp_i    (resp),
        .fault_i   (fault),
        .busy_o    (busy)
    );

    always #5 clock = ~clock;

    // Bus slave: rejects in the request cycle when faulting, otherwise
    // answers respDelay cycles after the request with rdataVal.
    always @(negedge clock) begin
        resp  = 1'b0;
        rdata = $urandom;
        if (reset) begin
            respCnt = 0;
        end else if (respCnt > 0) begin
            respCnt = respCnt - 1;
            if (respCnt == 0) begin
                resp  = 1'b1;
                rdata = rdataVal;
            end
        end
        fault = req && faultMode;
        if (req && !faultMode && respEnable) respCnt = respDelay;
    end

    // Record TX pushes and bus requests once inputs have settled.
    always @(negedge clock) begin
        #2;
        cyc++;
        if (txReq) begin
            txLog.push_back(txData);
            lastTxCyc = cyc;
            if (txFull) fullViolations++;
        end
        if (req) begin
            reqAddr.push_back(addr);
            reqWdata.push_back(wdata);
            reqW.push_back(wRb);
            reqAcc.push_back(acc);
            reqCyc = cyc;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        txLog.delete();
        reqAddr.delete();
        reqWdata.delete();
        reqW.delete();
        reqAcc.delete();
    endtask

    task automatic sendByte(input logic [7:0] b);
        rxValid = 1'b1;
        rxData  = b;
        @(negedge clock);
        rxValid = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge clock);
            n++;
        end
        checkOutput("busy drop", 32'(busy), 32'd0);
    endtask

    // Sends one frame and checks the resulting access and response.
    // mode 0: plain, mode 1: extra byte during WAIT, mode 2: TX full during data.
    task automatic applyStimulus(input logic [7:0] cmd, input logic [31:0] a,
                                 input logic [31:0] wd, input bit doFault,
                                 input bit doResp, input int delay,
                                 input logic [31:0] rd, input int mode,
                                 input int gapMax);
        logic [7:0] frame[$];
        logic [7:0] expTx[$];
        logic [1:0] code;
        bit         bad;
        bit         ovrExp;
        faultMode  = doFault;
        respEnable = doResp;
        respDelay  = delay;
        rdataVal   = rd;
        bad = (cmd[6:2] != 5'd0) || (cmd[1:0] == 2'd3);
        frame.push_back(cmd);
        if (!bad) begin
            for (int k = 0; k < 4; k++) frame.push_back(a[8*k +: 8]);
            if (cmd[7]) for (int k = 0; k < 4; k++) frame.push_back(wd[8*k +: 8]);
        end
        for (int k = 0; k < frame.size(); k++) begin
            sendByte(frame[k]);
            if (k < frame.size() - 1) repeat ($urandom_range(gapMax, 0)) @(negedge clock);
        end
        if (!bad) checkOutput("req latency", 32'(req), 32'd1);
        ovrExp = 1'b0;
        if (mode == 1 && !bad) begin
            @(negedge clock);
            sendByte(8'h55);
            ovrExp = 1'b1;
        end
        if (mode == 2 && !bad) begin
            repeat (3) @(negedge clock);
            txFull = 1'b1;
            repeat (50) @(negedge clock);
            checkOutput("held while full", 32'(txLog.size()), 32'd1);
            txFull = 1'b0;
        end
        waitIdle();

        if (bad) code = 2'd3;
        else if (doFault) code = 2'd1;
        else if (!doResp) code = 2'd2;
        else code = 2'd0;
        expTx.push_back({ovrExp, 5'b00000, code});
        if (!bad && !cmd[7] && code == 2'd0)
            for (int k = 0; k < 4; k++) expTx.push_back(rd[8*k +: 8]);

        checkOutput("tx count", 32'(txLog.size()), 32'(expTx.size()));
        for (int k = 0; k < expTx.size(); k++)
            if (k < txLog.size()) checkOutput("tx byte", 32'(txLog[k]), 32'(expTx[k]));
        checkOutput("req count", 32'(reqAddr.size()), bad ? 32'd0 : 32'd1);
        if (!bad && reqAddr.size() > 0) begin
            checkOutput("req addr", reqAddr[0], a);
            checkOutput("req w_rb", 32'(reqW[0]), 32'(cmd[7]));
            checkOutput("req acc", 32'(reqAcc[0]), 32'(cmd[1:0]));
            if (cmd[7]) checkOutput("req wdata", reqWdata[0], wd);
        end
        if (!bad && !doFault && !doResp)
            checkOutput("timeout wait cycles", 32'(lastTxCyc - reqCyc), 32'(BT + 2));
        clearLogs();
    endtask

    initial begin
        logic [7:0] c;
        bit         f;
        bit         r;
        reset   = 1'b1;
        rxValid = 1'b0;
        rxData  = 8'h00;
        txFull  = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset req", 32'(req), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset tx_req", 32'(txReq), 32'd0);
        checkOutput("reset tx_data", 32'(txData), 32'd0);
        checkOutput("reset addr", addr, 32'd0);
        checkOutput("reset wdata", wdata, 32'd0);
        checkOutput("reset acc", 32'(acc), 32'd0);
        checkOutput("reset w_rb", 32'(wRb), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        clearLogs();

        $display("[TB] directed read and write frames");
        applyStimulus(8'h00, 32'h20000010, 32'h0, 1'b0, 1'b1, 1, 32'hDEADBEEF, 0, 0);
        applyStimulus(8'h82, 32'h00000004, 32'h12345678, 1'b0, 1'b1, 1, 32'h0, 0, 0);
        applyStimulus(8'h81, 32'hA5A50000, 32'hCAFEF00D, 1'b1, 1'b1, 1, 32'h0, 0, 0);
        applyStimulus(8'h01, 32'h00001000, 32'h0, 1'b0, 1'b0, 1, 32'h0, 0, 0);
        applyStimulus(8'h43, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h0, 0, 0);
        applyStimulus(8'h03, 32'h0, 32'h0, 1'b0, 1'b1, 1, 32'h0, 0, 0);

        $display("[TB] frame timeout");
        sendByte(8'h00);
        sendByte(8'h10);
        sendByte(8'h00);
        repeat (FT - 1) @(negedge clock);
        checkOutput("busy before frame timeout", 32'(busy), 32'd1);
        @(negedge clock);
        checkOutput("busy after frame timeout", 32'(busy), 32'd0);
        repeat (3) @(negedge clock);
        checkOutput("timeout req count", 32'(reqAddr.size()), 32'd0);
        checkOutput("timeout tx count", 32'(txLog.size()), 32'd0);
        clearLogs();
        applyStimulus(8'h02, 32'h30000020, 32'h0, 1'b0, 1'b1, 2, 32'h0BADF00D, 0, 2);

        $display("[TB] tx backpressure and overrun");
        applyStimulus(8'h00, 32'h40000000, 32'h0, 1'b0, 1'b1, 1, 32'h11223344, 2, 0);
        applyStimulus(8'h01, 32'h50000002, 32'h0, 1'b0, 1'b1, 5, 32'h55667788, 1, 0);
        applyStimulus(8'h80, 32'h60000003, 32'h000000AB, 1'b0, 1'b1, 1, 32'h0, 0, 0);

        $display("[TB] reset during WAIT");
        respEnable = 1'b0;
        faultMode  = 1'b0;
        sendByte(8'h00);
        for (int k = 0; k < 4; k++) sendByte(8'h70 + 8'(k));
        repeat (2) @(negedge clock);
        sendByte(8'h99);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        checkOutput("mid reset req", 32'(req), 32'd0);
        checkOutput("mid reset busy", 32'(busy), 32'd0);
        checkOutput("mid reset tx_req", 32'(txReq), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (300) @(negedge clock);
        checkOutput("no tx after reset", 32'(txLog.size()), 32'd0);
        clearLogs();
        applyStimulus(8'h00, 32'h70000000, 32'h0, 1'b0, 1'b1, 1, 32'h89ABCDEF, 0, 0);

        $display("[TB] random frames");
        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(9, 0) == 0) begin
                c = 8'($urandom);
                if (c[6:2] == 5'd0 && c[1:0] != 2'd3) c[3] = 1'b1;
            end else begin
                c = {1'($urandom_range(1, 0)), 5'b00000, 2'($urandom_range(2, 0))};
            end
            f = ($urandom_range(6, 0) == 0);
            r = ($urandom_range(7, 0) != 0);
            applyStimulus(c, $urandom, $urandom, f, r, $urandom_range(6, 1),
                          $urandom, 0, 3);
        end

        checkOutput("tx_req while full", 32'(fullViolations), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
